// File: rtl/syncfifo_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module  : syncfifo_prog_pkg
// Purpose : Shared definitions for the programmable synchronous FIFO cell:
//           count/threshold width derivation, storage capacity and the
//           memory implementation style names.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package syncfifo_prog_pkg;

  localparam string RAM_STYLE_BLOCK = "block";
  localparam string RAM_STYLE_DIST  = "distributed";

  // One extra bit over the address so a completely full memory (plus the
  // FWFT output register) is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Words the cell can hold: the memory, plus the output register in FWFT.
  function automatic int fifo_capacity(input int addr_width, input int fwft_en);
    return (1 << addr_width) + ((fwft_en != 0) ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gnrl_dfflr.sv
`default_nettype none
// ============================================================================
// Module  : gnrl_dfflr
// Purpose : General load-enabled flop with synchronous active-high reset to 0.
// Ports   : clk  - clock
//           rst  - synchronous reset, clears qout
//           lden - load enable
//           dnxt - next value
//           qout - registered value
// Rev     : 1.1  synchronous reset added
// ============================================================================
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/syncfifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : syncfifo_ram
// Purpose : Simple dual-port memory, synchronous write, asynchronous read.
//           Contents are not reset.
// Ports   : clk   - clock
//           we    - write enable
//           waddr - write address
//           wdata - write data
//           raddr - read address
//           rdata - read data (combinational from raddr)
// Rev     : 1.0  initial release
// ============================================================================
module syncfifo_ram
  import syncfifo_prog_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter string RAM_STYLE  = RAM_STYLE_DIST
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int  DEPTH    = 1 << ADDR_WIDTH;
  localparam bit  IS_BLOCK = (RAM_STYLE == RAM_STYLE_BLOCK);

  generate
    if (IS_BLOCK) begin : g_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end
      assign rdata = mem[raddr];
    end else begin : g_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/syncfifo_prog.sv
`default_nettype none
// ============================================================================
// Module  : syncfifo_prog
// Purpose : Single-clock FIFO with programmable almost-full/almost-empty
//           thresholds, occupancy count and sticky overflow/underflow flags.
//           FWFT_EN=1: first-word fall-through via a registered output stage.
//           FWFT_EN=0: one-cycle read latency qualified by dout_valid.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           din, wr_en, full     - write side
//           rd_en, dout,
//           dout_valid, empty    - read side
//           prog_full(_th),
//           prog_empty(_th)      - threshold flags and thresholds
//           count                - words held (incl. FWFT output register)
//           overflow, underflow,
//           err_clr              - sticky error flags and their clear
// Rev     : 1.0  initial release
// ============================================================================
module syncfifo_prog
  import syncfifo_prog_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter string RAM_STYLE  = RAM_STYLE_DIST,
  parameter int    FWFT_EN    = 1,
  localparam int   CNT_W      = cnt_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  prog_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  empty,
  output logic                  prog_empty,
  input  logic [CNT_W-1:0]      prog_full_th,
  input  logic [CNT_W-1:0]      prog_empty_th,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(1 << ADDR_WIDTH);
  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(fifo_capacity(ADDR_WIDTH, FWFT_EN));

  logic [CNT_W-1:0]      wptr, rptr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc;
  logic                  rptr_inc;   // memory word consumed this cycle
  logic                  dout_ld;    // output register loads mem[rptr]
  logic                  vld_ld, vld_nxt, vld_q;

  syncfifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_STYLE  (RAM_STYLE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (din),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  generate
    if (FWFT_EN != 0) begin : g_fwft
      logic mem_empty;
      logic prefetch;
      assign mem_empty = (wptr == rptr);
      assign empty     = ~vld_q;
      assign full      = (count == CAP_C);
      assign rd_acc    = rd_en & vld_q;
      // Refill the output register whenever it is (or is about to be) free.
      assign prefetch  = ~mem_empty & (~vld_q | rd_acc);
      assign rptr_inc  = prefetch;
      assign dout_ld   = prefetch;
      assign vld_ld    = prefetch | rd_acc;
      assign vld_nxt   = prefetch;
    end else begin : g_std
      assign empty    = (count == '0);
      assign full     = (count == DEPTH_C);
      assign rd_acc   = rd_en & ~empty;
      assign rptr_inc = rd_acc;
      assign dout_ld  = rd_acc;
      // dout_valid is a single-cycle pulse following each accepted read.
      assign vld_ld   = 1'b1;
      assign vld_nxt  = rd_acc;
    end
  endgenerate

  assign wr_acc     = wr_en & ~full;
  assign dout_valid = vld_q;
  assign prog_full  = (count >= prog_full_th);
  assign prog_empty = (count <= prog_empty_th);

  gnrl_dfflr #(.DW(CNT_W)) u_wptr (
    .clk(clk), .rst(rst), .lden(wr_acc),
    .dnxt(wptr + CNT_W'(1)), .qout(wptr)
  );

  gnrl_dfflr #(.DW(CNT_W)) u_rptr (
    .clk(clk), .rst(rst), .lden(rptr_inc),
    .dnxt(rptr + CNT_W'(1)), .qout(rptr)
  );

  // Counts from the write edge, independent of when the prefetch happens.
  gnrl_dfflr #(.DW(CNT_W)) u_count (
    .clk(clk), .rst(rst), .lden(wr_acc ^ rd_acc),
    .dnxt(count + CNT_W'(wr_acc) - CNT_W'(rd_acc)), .qout(count)
  );

  gnrl_dfflr #(.DW(DATA_WIDTH)) u_dout (
    .clk(clk), .rst(rst), .lden(dout_ld),
    .dnxt(mem_rdata), .qout(dout)
  );

  gnrl_dfflr #(.DW(1)) u_vld (
    .clk(clk), .rst(rst), .lden(vld_ld),
    .dnxt(vld_nxt), .qout(vld_q)
  );

  // Sticky error flags; clear takes priority over a coincident set.
  gnrl_dfflr #(.DW(1)) u_ovf (
    .clk(clk), .rst(rst), .lden(1'b1),
    .dnxt(~err_clr & (overflow | (wr_en & full))), .qout(overflow)
  );

  gnrl_dfflr #(.DW(1)) u_udf (
    .clk(clk), .rst(rst), .lden(1'b1),
    .dnxt(~err_clr & (underflow | (rd_en & empty))), .qout(underflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_syncfifo_prog.sv
`default_nettype none
// ============================================================================
// Module  : tb_syncfifo_prog
// Purpose : Directed self-checking bench for syncfifo_prog. One FWFT
//           instance (f_*) and one standard-mode instance (s_*) share the
//           clock and reset.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_syncfifo_prog;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int CW = AW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // FWFT instance signals
  logic [DW-1:0] f_din = '0;
  logic          f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
  logic [CW-1:0] f_pft = 4'd9, f_pet = 4'd0;
  logic          f_full, f_pfull, f_dvalid, f_empty, f_pempty, f_ovf, f_udf;
  logic [DW-1:0] f_dout;
  logic [CW-1:0] f_count;

  // Standard-mode instance signals
  logic [DW-1:0] s_din = '0;
  logic          s_wr = 1'b0, s_rd = 1'b0, s_clr = 1'b0;
  logic [CW-1:0] s_pft = 4'd8, s_pet = 4'd0;
  logic          s_full, s_pfull, s_dvalid, s_empty, s_pempty, s_ovf, s_udf;
  logic [DW-1:0] s_dout;
  logic [CW-1:0] s_count;

  int total = 0;
  int bad   = 0;

  syncfifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("distributed"), .FWFT_EN(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .din(f_din), .wr_en(f_wr), .full(f_full),
    .prog_full(f_pfull), .rd_en(f_rd), .dout(f_dout), .dout_valid(f_dvalid),
    .empty(f_empty), .prog_empty(f_pempty), .prog_full_th(f_pft),
    .prog_empty_th(f_pet), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .err_clr(f_clr)
  );

  syncfifo_prog #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("block"), .FWFT_EN(0)
  ) u_std (
    .clk(clk), .rst(rst), .din(s_din), .wr_en(s_wr), .full(s_full),
    .prog_full(s_pfull), .rd_en(s_rd), .dout(s_dout), .dout_valid(s_dvalid),
    .empty(s_empty), .prog_empty(s_pempty), .prog_full_th(s_pft),
    .prog_empty_th(s_pet), .count(s_count), .overflow(s_ovf),
    .underflow(s_udf), .err_clr(s_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    rst = 1'b0;
    chk("rst_f_empty", f_empty, 1);
    chk("rst_f_full", f_full, 0);
    chk("rst_f_dvalid", f_dvalid, 0);
    chk("rst_f_pempty", f_pempty, 1);
    chk("rst_f_count", f_count, 0);
    chk("rst_f_dout", f_dout, 0);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_dvalid", s_dvalid, 0);
    chk("rst_s_ovf", s_ovf, 0);

    // ---------------- 1: FWFT fill to full ----------------
    for (int i = 1; i <= 9; i++) begin
      f_din = DW'(i); f_wr = 1'b1;
      tick();
    end
    chk("t1_full", f_full, 1);
    chk("t1_count", f_count, 9);
    chk("t1_dout", f_dout, 8'h01);
    chk("t1_ovf_pre", f_ovf, 0);
    f_din = 8'h0A;
    tick();
    f_wr = 1'b0;
    chk("t1_ovf", f_ovf, 1);
    chk("t1_count_after_ovf", f_count, 9);
    for (int i = 1; i <= 9; i++) begin
      chk("t1_drain_dout", f_dout, 32'(i));
      chk("t1_drain_dvalid", f_dvalid, 1);
      f_rd = 1'b1;
      tick();
    end
    f_rd = 1'b0;
    chk("t1_empty", f_empty, 1);
    chk("t1_count0", f_count, 0);
    f_clr = 1'b1; tick(); f_clr = 1'b0;
    chk("t1_ovf_clr", f_ovf, 0);

    // ---------------- 2: FWFT latency ----------------
    f_din = 8'hA5; f_wr = 1'b1;
    tick();
    f_wr = 1'b0;
    chk("t2_empty_n", f_empty, 1);
    chk("t2_count_n", f_count, 1);
    tick();
    chk("t2_empty_n1", f_empty, 0);
    chk("t2_dout_n1", f_dout, 8'hA5);
    f_rd = 1'b1;
    tick();
    f_rd = 1'b0;
    chk("t2_empty_rd", f_empty, 1);
    chk("t2_count_rd", f_count, 0);
    chk("t2_dout_hold", f_dout, 8'hA5);

    // ---------------- 3: standard drain ----------------
    s_wr = 1'b1;
    s_din = 8'h10; tick();
    s_din = 8'h20; tick();
    s_din = 8'h30; tick();
    s_wr = 1'b0;
    chk("t3_count3", s_count, 3);
    chk("t3_dvalid_idle", s_dvalid, 0);
    s_rd = 1'b1;
    tick();
    chk("t3_dv1", s_dvalid, 1); chk("t3_d1", s_dout, 8'h10);
    tick();
    chk("t3_dv2", s_dvalid, 1); chk("t3_d2", s_dout, 8'h20);
    tick();
    chk("t3_dv3", s_dvalid, 1); chk("t3_d3", s_dout, 8'h30);
    chk("t3_udf_pre", s_udf, 0);
    tick();
    s_rd = 1'b0;
    chk("t3_dv4", s_dvalid, 0);
    chk("t3_udf", s_udf, 1);
    chk("t3_empty", s_empty, 1);
    chk("t3_dout_hold", s_dout, 8'h30);
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    chk("t3_udf_clr", s_udf, 0);

    // ---------------- 4: simultaneous read/write at full ----------------
    s_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_din = 8'h40 + DW'(i);
      tick();
    end
    chk("t4_full", s_full, 1);
    chk("t4_count8", s_count, 8);
    s_din = 8'hEE; s_rd = 1'b1;
    tick();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("t4_count7", s_count, 7);
    chk("t4_ovf", s_ovf, 1);
    chk("t4_rd_dout", s_dout, 8'h40);
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    chk("t4_ovf_clr", s_ovf, 0);
    s_rd = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t4_drain", s_dout, 8'h40 + 32'(i));
    end
    s_rd = 1'b0;
    chk("t4_empty", s_empty, 1);

    // ---------------- 5: thresholds ----------------
    s_pft = 4'd6; s_pet = 4'd2;
    s_wr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      s_din = DW'(k);
      tick();
      chk("t5_up_pempty", s_pempty, (k <= 2) ? 1 : 0);
      chk("t5_up_pfull", s_pfull, (k >= 6) ? 1 : 0);
    end
    s_wr = 1'b0;
    s_rd = 1'b1;
    for (int k = 5; k >= 0; k--) begin
      tick();
      chk("t5_dn_pempty", s_pempty, (k <= 2) ? 1 : 0);
      chk("t5_dn_pfull", s_pfull, (k >= 6) ? 1 : 0);
    end
    s_rd = 1'b0;
    s_pft = 4'd0;
    #1;
    chk("t5_pft0", s_pfull, 1);
    s_pft = 4'd8;

    // ---------------- 6: mid-operation reset and pointer wrap ----------------
    f_rd = 1'b1; tick(); f_rd = 1'b0;
    chk("t6_udf_set", f_udf, 1);
    f_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_din = 8'h60 + DW'(i);
      tick();
    end
    chk("t6_count5", f_count, 5);
    f_rd = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    chk("t6_count0", f_count, 0);
    chk("t6_empty", f_empty, 1);
    chk("t6_dout0", f_dout, 0);
    chk("t6_udf0", f_udf, 0);
    chk("t6_ovf0", f_ovf, 0);
    for (int i = 0; i < 20; i++) begin
      f_din = 8'h80 + DW'(i); s_din = 8'hC0 + DW'(i);
      f_wr = 1'b1; s_wr = 1'b1;
      tick();
      f_wr = 1'b0; s_wr = 1'b0; s_rd = 1'b1;
      tick();
      s_rd = 1'b0;
      chk("t6_f_dout", f_dout, 8'h80 + 32'(i));
      chk("t6_f_dvalid", f_dvalid, 1);
      chk("t6_s_dout", s_dout, 8'hC0 + 32'(i));
      chk("t6_s_dvalid", s_dvalid, 1);
      f_rd = 1'b1;
      tick();
      f_rd = 1'b0;
    end
    chk("t6_f_end_count", f_count, 0);
    chk("t6_s_end_count", s_count, 0);
    chk("t6_f_end_empty", f_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
